// File: rtl/slot_reel_judge.sv
// slot_reel_judge: spin controller and scorer for a three-reel slot machine with a saturating credit balance
module slot_reel_judge #(
  parameter int CREDIT_W     = 8,
  parameter int INIT_CREDITS = 5,
  parameter int PAIR_PAY     = 2,
  parameter int JACKPOT_PAY  = 10,
  parameter int SHOW_CYCLES  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          reel_value,
  input  logic                start_btn,
  input  logic                stop_btn,
  output logic                running,
  output logic [3:0]          reel0,
  output logic [3:0]          reel1,
  output logic [3:0]          reel2,
  output logic                win,
  output logic                jackpot,
  output logic [CREDIT_W-1:0] credits,
  output logic                done
);
  localparam int CNT_W = $clog2(SHOW_CYCLES + 1);
  localparam logic [CREDIT_W:0] MAX_CREDITS = {1'b0, {CREDIT_W{1'b1}}};
  typedef enum logic [2:0] {IDLE, SPIN0, SPIN1, SPIN2, JUDGE, SHOW} state_t;
  state_t              state_q;
  logic                start_q, stop_q, start_p, stop_p;
  logic [3:0]          reel0_q, reel1_q, reel2_q;
  logic                win_q, jackpot_q, done_q;
  logic [CREDIT_W-1:0] credits_q, credits_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CREDIT_W:0]   sum_d;
  logic                jp_d, pair_d;
  assign start_p   = start_btn & ~start_q;
  assign stop_p    = stop_btn & ~stop_q;
  assign jp_d      = (reel0_q == reel1_q) && (reel1_q == reel2_q);
  assign pair_d    = !jp_d && ((reel0_q == reel1_q) || (reel1_q == reel2_q));
  assign sum_d     = {1'b0, credits_q} + (jp_d ? (CREDIT_W+1)'(JACKPOT_PAY) :
                                          pair_d ? (CREDIT_W+1)'(PAIR_PAY) : '0);
  assign credits_d = (sum_d > MAX_CREDITS) ? MAX_CREDITS[CREDIT_W-1:0] : sum_d[CREDIT_W-1:0];
  assign running   = (state_q == SPIN0) || (state_q == SPIN1) || (state_q == SPIN2);
  assign reel0     = reel0_q;
  assign reel1     = reel1_q;
  assign reel2     = reel2_q;
  assign win       = win_q;
  assign jackpot   = jackpot_q;
  assign credits   = credits_q;
  assign done      = done_q;
  // Spin sequencing, reel capture, scoring and result display window
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      reel0_q   <= '0;
      reel1_q   <= '0;
      reel2_q   <= '0;
      win_q     <= 1'b0;
      jackpot_q <= 1'b0;
      done_q    <= 1'b0;
      credits_q <= CREDIT_W'(INIT_CREDITS);
      cnt_q     <= '0;
    end else begin
      start_q <= start_btn;
      stop_q  <= stop_btn;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start_p && credits_q != '0) begin
          state_q   <= SPIN0;
          credits_q <= credits_q - CREDIT_W'(1);
          reel0_q   <= '0;
          reel1_q   <= '0;
          reel2_q   <= '0;
          win_q     <= 1'b0;
          jackpot_q <= 1'b0;
        end
        SPIN0: if (stop_p) begin
          reel0_q <= reel_value;
          state_q <= SPIN1;
        end
        SPIN1: if (stop_p) begin
          reel1_q <= reel_value;
          state_q <= SPIN2;
        end
        SPIN2: if (stop_p) begin
          reel2_q <= reel_value;
          state_q <= JUDGE;
        end
        JUDGE: begin
          jackpot_q <= jp_d;
          win_q     <= pair_d;
          credits_q <= credits_d;
          cnt_q     <= CNT_W'(SHOW_CYCLES - 1);
          state_q   <= SHOW;
        end
        SHOW: if (cnt_q == '0) begin
          done_q    <= 1'b1;
          win_q     <= 1'b0;
          jackpot_q <= 1'b0;
          state_q   <= IDLE;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slot_reel_judge.sv
// tb_slot_reel_judge: randomized scoreboard bench for slot_reel_judge against a credit/payout model
module tb_slot_reel_judge;
  localparam int INIT = 5;
  localparam int PP   = 2;
  localparam int JP   = 10;
  localparam int SHOW = 4;
  localparam int MAXC = 255;
  typedef struct {
    logic [3:0] r0, r1, r2;
    bit         w, j;
    int         cr;
  } exp_t;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] reel_value = '0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       running, win, jackpot, done;
  logic [3:0] reel0, reel1, reel2;
  logic [7:0] credits;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         mc = INIT;
  exp_t       q[$];
  int         hi_cnt = 0;
  bit         seen_w = 0, seen_j = 0;
  slot_reel_judge #(.CREDIT_W(8), .INIT_CREDITS(INIT), .PAIR_PAY(PP), .JACKPOT_PAY(JP), .SHOW_CYCLES(SHOW)) dut (
    .clock(clock), .reset(reset), .reel_value(reel_value), .start_btn(start_btn), .stop_btn(stop_btn),
    .running(running), .reel0(reel0), .reel1(reel1), .reel2(reel2), .win(win), .jackpot(jackpot),
    .credits(credits), .done(done)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic capture(input logic [3:0] v, input int n);
    reel_value = v;
    stop_btn = 1'b1;
    repeat (n) begin
      tick();
      reel_value = 4'($urandom);
    end
    stop_btn = 1'b0;
    tick();
  endtask
  task automatic spin(input logic [3:0] a, b, c, input bit hold, input bit poke);
    exp_t e;
    int   pay;
    mc   = mc - 1;
    pay  = (a == b && b == c) ? JP : ((a == b || b == c) ? PP : 0);
    e.r0 = a; e.r1 = b; e.r2 = c;
    e.w  = (pay == PP);
    e.j  = (pay == JP);
    e.cr = (mc + pay > MAXC) ? MAXC : mc + pay;
    q.push_back(e);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    chk("running_after_start", int'(running), 1);
    chk("credits_after_deduct", int'(credits), mc);
    chk("reels_cleared", int'({reel0, reel1, reel2}), 0);
    mc = e.cr;
    capture(a, hold ? 10 : 1);
    if (poke) begin
      start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      tick();
      chk("running_after_spin1_start", int'(running), 1);
    end
    capture(b, 1);
    capture(c, 1);
    repeat (SHOW + 4) tick();
  endtask
  // Monitor: pops the expected result each time the DUT signals completion
  always @(negedge clock) begin
    if (reset) begin
      hi_cnt = 0; seen_w = 0; seen_j = 0;
    end else begin
      if (win || jackpot) hi_cnt++;
      seen_w |= win;
      seen_j |= jackpot;
      if (done) begin
        if (q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("reel0", int'(reel0), int'(e.r0));
          chk("reel1", int'(reel1), int'(e.r1));
          chk("reel2", int'(reel2), int'(e.r2));
          chk("win", int'(seen_w), int'(e.w));
          chk("jackpot", int'(seen_j), int'(e.j));
          chk("credits", int'(credits), e.cr);
          chk("show_cycles", hi_cnt, (e.w || e.j) ? SHOW : 0);
          chk("flags_clear_in_idle", int'({win, jackpot}), 0);
        end
        hi_cnt = 0; seen_w = 0; seen_j = 0;
      end
    end
  end
  initial begin
    repeat (3) tick();
    chk("reset_credits", int'(credits), INIT);
    chk("reset_running", int'(running), 0);
    chk("reset_outputs", int'({reel0, reel1, reel2, win, jackpot, done}), 0);
    reset = 1'b0;
    tick();
    spin(4'h9, 4'h9, 4'h9, 0, 0);
    spin(4'h3, 4'h3, 4'h7, 0, 0);
    spin(4'h5, 4'h8, 4'h5, 0, 0);
    spin(4'h7, 4'h3, 4'h3, 1, 1);
    for (int i = 0; i < 40; i++)
      if (mc > 0) spin(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom));
    while (mc > 0) spin(4'h1, 4'h2, 4'h3, 0, 0);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
    chk("empty_start_running", int'(running), 0);
    chk("empty_start_credits", int'(credits), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mc = INIT;
    tick();
    while (mc < MAXC) spin(4'($urandom), 4'h0, 4'h0, 0, 0);
    spin(4'hA, 4'hA, 4'hA, 0, 0);
    chk("saturated_credits", int'(credits), MAXC);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    capture(4'h4, 1);
    capture(4'h6, 1);
    chk("in_spin2_running", int'(running), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mc = INIT;
    tick();
    chk("abort_credits", int'(credits), INIT);
    chk("abort_running", int'(running), 0);
    chk("abort_reels", int'({reel0, reel1, reel2}), 0);
    spin(4'hC, 4'hC, 4'h2, 0, 0);
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    chk("scoreboard_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/slot_reel_judge.md
Name: slot_reel_judge

Overview:
- Controller and scorer on the consuming side of the slot-machine reel LFSR.
- Drives the reel's `running` input and takes a player start press that costs one credit.
- Captures the live 4-bit reel value on each of three stop presses, then compares the three captured symbols.
- Reports pair or jackpot wins, keeps a saturating credit balance, and holds the result for a display window.

Parameters:
- CREDIT_W, 8, width of the credit counter.
- INIT_CREDITS, 5, credit value loaded on reset.
- PAIR_PAY, 2, credits added when exactly two adjacent reels match.
- JACKPOT_PAY, 10, credits added when all three reels match.
- SHOW_CYCLES, 4, number of cycles the result is held in SHOW (must be ≥1).

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high; returns the block to IDLE.
- reel_value  input  4  live reel symbol from the reel LFSR.
- start_btn  input  1  synchronised level; its rising edge requests a spin.
- stop_btn  input  1  synchronised level; its rising edge stops the current reel.
- running  output  1  high while reels spin; connects to the reel LFSR `running` input.
- reel0  output  4  captured symbol, reel 0.
- reel1  output  4  captured symbol, reel 1.
- reel2  output  4  captured symbol, reel 2.
- win  output  1  high in SHOW when the result is a pair.
- jackpot  output  1  high in SHOW when all three reels match.
- credits  output  CREDIT_W  current credit balance.
- done  output  1  one-cycle pulse on the SHOW->IDLE transition.

Behaviour:
- Reset (synchronous, dominant over everything):
  - state=IDLE; running=0.
  - reel0/1/2=0; win=0; jackpot=0; done=0.
  - credits=INIT_CREDITS; show counter=0.
  - Button edge-detect history registers cleared to 0, so a button already held high at reset release counts as an edge.
- Edge detect:
  - start_p = start_btn & ~start_q; stop_p = stop_btn & ~stop_q.
  - start_q and stop_q are registered every cycle.
- States: IDLE, SPIN0, SPIN1, SPIN2, JUDGE, SHOW.
- IDLE:
  - If start_p and credits≠0: go to SPIN0; credits−=1; clear reel0/1/2, win and jackpot to 0.
  - If start_p and credits==0: ignored; stay in IDLE.
  - stop_p is ignored.
- SPIN0, SPIN1, SPIN2:
  - running=1 in all three states, registered, asserted from the cycle the state is entered.
  - On stop_p in SPINk: reelk <= reel_value sampled that cycle; go to the next state (SPIN2 -> JUDGE).
  - Only one reel is captured per stop_p.
  - start_p is ignored.
  - Without stop_p the block stays in the state indefinitely; there is no timeout.
- JUDGE (exactly 1 cycle, running=0):
  - Jackpot: reel0==reel1==reel2 → jackpot<=1; credits += JACKPOT_PAY.
  - Pair: otherwise, if reel0==reel1 or reel1==reel2 → win<=1; credits += PAIR_PAY.
  - reel0==reel2 alone is not a win.
  - Addition saturates at 2^CREDIT_W−1.
  - Load show counter with SHOW_CYCLES−1; go to SHOW.
- SHOW:
  - win/jackpot are held.
  - Counter decrements each cycle.
  - When the counter is 0: done<=1 for one cycle, go to IDLE; win/jackpot return to 0 on entry to IDLE.
  - Buttons are ignored.
- Latencies:
  - start_p to running=1: 1 cycle.
  - Last stop_p to win/jackpot valid: 2 cycles (capture, then JUDGE).
- Simultaneous start_p and stop_p: only the edge relevant to the current state acts.
- Reset in any state aborts the spin; the deducted credit is not refunded (credits reload INIT_CREDITS).
- Outputs are registered except running, which is a registered decode of the state.

Test Plan:
- Reset and spin start: reset, then start_p → credits 5→4, running=1 from the next cycle, reel0/1/2=0.
- Jackpot: stop_p three times with reel_value=4'h9 each time → jackpot=1 for 4 cycles, win=0, credits 4→14, done pulses once as the block returns to IDLE.
- Pair and non-adjacent: captures 3,3,7 → win=1, credits +2; captures 5,8,5 → win=0, jackpot=0, credits unchanged.
- Credit exhaustion: INIT_CREDITS=1, spin with no win (1,2,3) → credits=0; a further start_p is ignored, state stays IDLE, running=0.
- Saturation: CREDIT_W=4, credits=14, jackpot spin → credits after deduct 13, then saturates at 15.
- Robustness:
  - stop_btn held high for 10 cycles in SPIN0 captures only reel0.
  - start_p during SPIN1 has no effect.
  - Reset asserted in SPIN2 → IDLE, credits=INIT_CREDITS, all reels 0.
